dcache_writeback_queue: RTL and testbench
=========================================

Name: dcache_writeback_queue

Overview:
- Downstream of the DCache miss unit: buffers victim lines evicted when a miss is granted a replacement way, then writes dirty victims to memory over the AXI write channel.
- Pulses a write-enable-done (wend) back to the miss unit, tagged with the miss-entry index, once the victim is safely captured. The miss unit may then refill that way.
- Offers a block-address lookup so the miss unit holds off an AXI read of a line still waiting for writeback.

Parameters:
- ENTRIES, 4: victim buffer depth; power of two, at least 2.
- BANKS, 16: 32-bit banks per line. One AXI beat per bank.
- BANK_BITS, 32: bits per bank, equal to the AXI data width.
- ADDR_W, 32: physical/virtual address width.
- OFFSET_W, 6: line offset bits, log2(BANKS*BANK_BITS/8).
- MISS_W, 2: miss-entry index width.
- AXI_ID, 1: AWID driven on every write.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enq_valid  in  1  victim presented this cycle.
- enq_ready  out  1  buffer can accept a dirty victim.
- enq_dirty  in  1  victim line is dirty.
- enq_addr  in  ADDR_W  victim line address; offset bits ignored.
- enq_data  in  BANKS*BANK_BITS  victim line, bank 0 in the LSBs.
- enq_miss_idx  in  MISS_W  miss entry that caused the eviction.
- wend  out  1  victim captured or discarded.
- wend_miss_idx  out  MISS_W  miss index for wend.
- lookup_addr  in  ADDR_W  address probed by the miss unit.
- lookup_hit  out  1  a valid entry holds the same block.
- aw_valid  out  1  AXI AWVALID.
- aw_ready  in  1  AXI AWREADY.
- aw_addr  out  ADDR_W  line-aligned address.
- aw_id  out  4  AXI_ID.
- aw_len  out  8  BANKS-1.
- aw_size  out  3  log2(BANK_BITS/8).
- aw_burst  out  2  2'b01 (INCR).
- w_valid  out  1  WVALID.
- w_ready  in  1  WREADY.
- w_data  out  BANK_BITS  current beat.
- w_strb  out  BANK_BITS/8  all ones.
- w_last  out  1  final beat.
- b_valid  in  1  BVALID.
- b_ready  out  1  BREADY.
- b_resp  in  2  BRESP.
- wb_error  out  1  sticky; set on any nonzero b_resp.

Behaviour:
- Reset: all entries invalid; head, tail and count are 0; state is IDLE. wend, aw_valid, w_valid, b_ready, lookup_hit and wb_error are all 0.
- Acceptance: a victim is accepted when enq_valid & (~enq_dirty | enq_ready).
- enq_ready = (count != ENTRIES). A dequeue in the same cycle does not raise ready.
- Dirty enqueue: write addr[ADDR_W-1:OFFSET_W], data and valid into entry tail. tail += 1, wrapping modulo ENTRIES.
- Clean enqueue: no entry is allocated.
- wend timing: for every accepted victim, dirty or clean, wend=1 and wend_miss_idx=enq_miss_idx in the next cycle. wend is a single-cycle pulse.
- Dirty victim not accepted (full): no wend. The miss unit keeps enq_valid asserted.
- Count update: count += accepted dirty enqueue, minus dequeue. A simultaneous enqueue and dequeue leaves count unchanged.
- lookup_hit is combinational: OR over all valid entries of (entry block address == lookup_addr block bits).
  - An entry being dequeued this cycle still hits.
  - An entry being enqueued this cycle does not hit until the next cycle.
- Write FSM:
  - IDLE: if entry head is valid, go to AW. aw_valid=1, aw_addr = {block, OFFSET_W zeros}; beat counter = 0.
  - AW: wait for aw_valid & aw_ready, then go to W. AW and W are not overlapped.
  - W: w_valid=1 and w_data = bank[beat] of entry head. On w_ready, beat += 1. w_last = (beat == BANKS-1). Handshake with w_last goes to B.
  - B: b_ready=1. On b_valid: clear entry head valid, head += 1 (wrapping), set wb_error if b_resp != 0, return to IDLE.
  - IDLE re-evaluates in the following cycle. Minimum is one idle cycle between bursts.
- AW/W signals hold stable while valid is high and ready is low.
- Reset mid-burst: the FSM returns to IDLE and all buffered entries are dropped. The bus is assumed to be reset together with the block.
- Wrap-around: head and tail use MISS-independent log2(ENTRIES)-bit pointers. Full and empty are distinguished by count, width log2(ENTRIES)+1.

Decomposition:
- Shared dcache package: OFFSET_W and BANKS, the line-data typedef (array of BANKS × BANK_BITS), the AXI burst/size constants, and the DCACHE write ID.
- One sub-module: dcache_wb_axi_fsm. It holds the AW/W/B state machine and beat counter, takes a line plus block address with a start/done handshake, and keeps the queue logic separate.

Test Plan:
- Clean enqueue (enq_dirty=0, miss_idx=2) → wend=1 with wend_miss_idx=2 next cycle; no AW ever issued; count stays 0.
- Dirty enqueue of addr 0x8000_1040, banks 0..15 = 0x100+i, aw_ready/w_ready tied high → AW addr 0x8000_1040, len 15; then 16 beats of 0x100..0x10F, w_last on beat 15; b_valid after 3 cycles → entry freed, count back to 0.
- Fill: 4 dirty enqueues with aw_ready held 0 → enq_ready=0 after the 4th. A 5th dirty enqueue produces no wend. Raising aw_ready and completing B lets the 5th be accepted and its wend fire.
- Lookup: entry at 0x2000_0000 pending → lookup_addr 0x2000_003C gives hit=1 and 0x2000_0040 gives hit=0. After B completes, hit=0.
- Backpressure: w_ready toggles 1,0,1,0 → w_data and w_last stable while stalled; exactly 16 accepted beats.
- b_resp=2'b10 → wb_error=1, sticky until rst. rst asserted during beat 7 → next cycle aw_valid=w_valid=0, count=0, lookup_hit=0.

Source files
------------

// File: rtl/dcache_writeback_queue_pkg.sv
// Shared DCache constants, line type and writeback FSM state encoding.
package dcache_writeback_queue_pkg;

   localparam int DC_BANKS     = 16;
   localparam int DC_BANK_BITS = 32;
   localparam int DC_OFFSET_W  = 6;

   typedef logic [DC_BANKS-1:0][DC_BANK_BITS-1:0] dc_line_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] DCACHE_WR_ID   = 4'd1;

   typedef enum logic [1:0] {WB_IDLE, WB_AW, WB_W, WB_B} wb_state_e;

   function automatic logic [2:0] axi_size(input int bank_bits);
      return 3'($clog2(bank_bits / 8));
   endfunction

   localparam logic [2:0] AXI_SIZE_BANK = axi_size(DC_BANK_BITS);

endpackage

// File: rtl/dcache_wb_axi_fsm.sv
// AXI write-burst engine: one AW, BANKS W beats, one B per victim line.
module dcache_wb_axi_fsm
   import dcache_writeback_queue_pkg::*;
#(
   parameter int BANKS     = DC_BANKS,
   parameter int BANK_BITS = DC_BANK_BITS,
   parameter int ADDR_W    = 32,
   parameter int OFFSET_W  = DC_OFFSET_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ADDR_W-OFFSET_W-1:0]    blk,
   input  logic [BANKS*BANK_BITS-1:0]    line,
   output logic                          done,
   output logic                          err,
   output logic                          aw_valid,
   input  logic                          aw_ready,
   output logic [ADDR_W-1:0]             aw_addr,
   output logic                          w_valid,
   input  logic                          w_ready,
   output logic [BANK_BITS-1:0]          w_data,
   output logic                          w_last,
   input  logic                          b_valid,
   output logic                          b_ready,
   input  logic [1:0]                    b_resp
);

   localparam int                BEAT_W    = $clog2(BANKS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BANKS - 1);

   wb_state_e                       state;
   logic [BEAT_W-1:0]               beat;
   logic [BANKS-1:0][BANK_BITS-1:0] banks;

   // The head entry is held by the queue until done, so these stay stable while stalled.
   assign banks   = line;
   assign aw_addr = {blk, {OFFSET_W{1'b0}}};
   assign w_data  = banks[beat];
   assign w_last  = w_valid & (beat == LAST_BEAT);
   assign done    = b_ready & b_valid;
   assign err     = done & (b_resp != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WB_IDLE;
         beat     <= '0;
         aw_valid <= 1'b0;
         w_valid  <= 1'b0;
         b_ready  <= 1'b0;
      end else begin
         case (state)
            WB_IDLE: begin
               if (start) begin
                  state    <= WB_AW;
                  aw_valid <= 1'b1;
                  beat     <= '0;
               end
            end
            WB_AW: begin
               if (aw_valid && aw_ready) begin
                  state    <= WB_W;
                  aw_valid <= 1'b0;
                  w_valid  <= 1'b1;
               end
            end
            WB_W: begin
               if (w_ready) begin
                  if (beat == LAST_BEAT) begin
                     state   <= WB_B;
                     w_valid <= 1'b0;
                     b_ready <= 1'b1;
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end
            end
            WB_B: begin
               if (b_valid) begin
                  state   <= WB_IDLE;
                  b_ready <= 1'b0;
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dcache_writeback_queue.sv
// Victim buffer between the DCache miss unit and the AXI write channel.
module dcache_writeback_queue
   import dcache_writeback_queue_pkg::*;
#(
   parameter int ENTRIES   = 4,
   parameter int BANKS     = DC_BANKS,
   parameter int BANK_BITS = DC_BANK_BITS,
   parameter int ADDR_W    = 32,
   parameter int OFFSET_W  = DC_OFFSET_W,
   parameter int MISS_W    = 2,
   parameter int AXI_ID    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic                       enq_dirty,
   input  logic [ADDR_W-1:0]          enq_addr,
   input  logic [BANKS*BANK_BITS-1:0] enq_data,
   input  logic [MISS_W-1:0]          enq_miss_idx,
   output logic                       wend,
   output logic [MISS_W-1:0]          wend_miss_idx,
   input  logic [ADDR_W-1:0]          lookup_addr,
   output logic                       lookup_hit,
   output logic                       aw_valid,
   input  logic                       aw_ready,
   output logic [ADDR_W-1:0]          aw_addr,
   output logic [3:0]                 aw_id,
   output logic [7:0]                 aw_len,
   output logic [2:0]                 aw_size,
   output logic [1:0]                 aw_burst,
   output logic                       w_valid,
   input  logic                       w_ready,
   output logic [BANK_BITS-1:0]       w_data,
   output logic [BANK_BITS/8-1:0]     w_strb,
   output logic                       w_last,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [1:0]                 b_resp,
   output logic                       wb_error
);

   localparam int PTR_W  = $clog2(ENTRIES);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BLK_W  = ADDR_W - OFFSET_W;
   localparam int LINE_W = BANKS * BANK_BITS;

   logic [BLK_W-1:0]  blk_q  [ENTRIES];
   logic [LINE_W-1:0] line_q [ENTRIES];
   logic [ENTRIES-1:0] vld_q;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic enq_accept;
   logic enq_push;
   logic deq;
   logic deq_err;
   logic unused_offset;

   assign unused_offset = ^{enq_addr[OFFSET_W-1:0], lookup_addr[OFFSET_W-1:0]};

   // Ready depends only on the registered count so it never combinationally follows a dequeue.
   assign enq_ready  = (count != CNT_W'(ENTRIES));
   assign enq_accept = enq_valid & (~enq_dirty | enq_ready);
   assign enq_push   = enq_valid & enq_dirty & enq_ready;

   assign aw_id    = 4'(AXI_ID);
   assign aw_len   = 8'(BANKS - 1);
   assign aw_size  = axi_size(BANK_BITS);
   assign aw_burst = AXI_BURST_INCR;
   assign w_strb   = '1;

   always_comb begin
      lookup_hit = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (vld_q[i] && (blk_q[i] == lookup_addr[ADDR_W-1:OFFSET_W]))
            lookup_hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_push) begin
         blk_q[tail]  <= enq_addr[ADDR_W-1:OFFSET_W];
         line_q[tail] <= enq_data;
      end
      if (enq_accept)
         wend_miss_idx <= enq_miss_idx;
   end

   // While not full, tail never aliases a valid head, so set and clear hit distinct entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         wend     <= 1'b0;
         wb_error <= 1'b0;
      end else begin
         wend <= enq_accept;
         if (enq_push) begin
            vld_q[tail] <= 1'b1;
            tail        <= tail + PTR_W'(1);
         end
         if (deq) begin
            vld_q[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         count    <= count + CNT_W'(enq_push) - CNT_W'(deq);
         wb_error <= wb_error | deq_err;
      end
   end

   dcache_wb_axi_fsm #(
      .BANKS     (BANKS),
      .BANK_BITS (BANK_BITS),
      .ADDR_W    (ADDR_W),
      .OFFSET_W  (OFFSET_W)
   ) u_axi_fsm (
      .clk      (clk),
      .rst      (rst),
      .start    (vld_q[head]),
      .blk      (blk_q[head]),
      .line     (line_q[head]),
      .done     (deq),
      .err      (deq_err),
      .aw_valid (aw_valid),
      .aw_ready (aw_ready),
      .aw_addr  (aw_addr),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .w_data   (w_data),
      .w_last   (w_last),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_resp   (b_resp)
   );

endmodule

// File: tb/tb_dcache_writeback_queue.sv
// Directed bench for the DCache victim writeback queue.
module tb_dcache_writeback_queue;

   logic         clk = 1'b0;
   logic         rst;
   logic         enq_valid, enq_ready, enq_dirty;
   logic [31:0]  enq_addr;
   logic [511:0] enq_data;
   logic [1:0]   enq_miss_idx;
   logic         wend;
   logic [1:0]   wend_miss_idx;
   logic [31:0]  lookup_addr;
   logic         lookup_hit;
   logic         aw_valid, aw_ready;
   logic [31:0]  aw_addr;
   logic [3:0]   aw_id;
   logic [7:0]   aw_len;
   logic [2:0]   aw_size;
   logic [1:0]   aw_burst;
   logic         w_valid, w_ready, w_last;
   logic [31:0]  w_data;
   logic [3:0]   w_strb;
   logic         b_valid, b_ready;
   logic [1:0]   b_resp;
   logic         wb_error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dcache_writeback_queue dut (
      .clk(clk), .rst(rst),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_dirty(enq_dirty),
      .enq_addr(enq_addr), .enq_data(enq_data), .enq_miss_idx(enq_miss_idx),
      .wend(wend), .wend_miss_idx(wend_miss_idx),
      .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .wb_error(wb_error)
   );

   function automatic logic [511:0] make_line(input logic [31:0] base);
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   task automatic do_reset();
      rst = 1'b1; enq_valid = 1'b0; enq_dirty = 1'b0; enq_addr = '0; enq_data = '0;
      enq_miss_idx = '0; lookup_addr = '0; aw_ready = 1'b1; w_ready = 1'b1;
      b_valid = 1'b0; b_resp = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic enq(input logic [31:0] addr, input logic dirty, input logic [1:0] idx,
                      input logic [31:0] base);
      enq_valid = 1'b1; enq_dirty = dirty; enq_addr = addr; enq_miss_idx = idx;
      enq_data = make_line(base);
      @(posedge clk); #1 enq_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({wend, aw_valid, w_valid, b_ready, lookup_hit, wb_error} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 000000",
                  {wend, aw_valid, w_valid, b_ready, lookup_hit, wb_error});
      end
      checks++;
      if ({enq_ready, dut.count} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL reset_ready_count got ready=%b count=%0d want ready=1 count=0",
                  enq_ready, dut.count);
      end
   endtask

   task automatic test_clean_enqueue();
      int seen;
      do_reset();
      enq(32'h3000_0000, 1'b0, 2'd2, 32'h300);
      @(negedge clk);
      checks++;
      if ({wend, wend_miss_idx} !== {1'b1, 2'd2}) begin
         errors++;
         $display("FAIL clean_wend got wend=%b idx=%0d want wend=1 idx=2", wend, wend_miss_idx);
      end
      @(negedge clk);
      checks++;
      if (wend !== 1'b0) begin
         errors++;
         $display("FAIL clean_wend_pulse got %b want 0", wend);
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (aw_valid) seen++;
      end
      checks++;
      if (seen != 0 || dut.count !== 3'd0) begin
         errors++;
         $display("FAIL clean_no_aw got aw_cycles=%0d count=%0d want 0 0", seen, dut.count);
      end
   endtask

   task automatic test_dirty_burst();
      int c, n;
      logic fin;
      do_reset();
      lookup_addr = 32'h8000_1040;
      enq(32'h8000_1040, 1'b1, 2'd1, 32'h100);
      @(negedge clk);
      checks++;
      if ({wend, wend_miss_idx} !== {1'b1, 2'd1}) begin
         errors++;
         $display("FAIL dirty_wend got wend=%b idx=%0d want 1 1", wend, wend_miss_idx);
      end
      c = 0;
      while (!aw_valid && c < 10) begin @(negedge clk); c++; end
      checks++;
      if ({aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id} !==
          {1'b1, 32'h8000_1040, 8'd15, 3'd2, 2'b01, 4'd1}) begin
         errors++;
         $display("FAIL dirty_aw got v=%b addr=%h len=%0d size=%0d burst=%0d id=%0d want 1 80001040 15 2 1 1",
                  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id);
      end
      n = 0; fin = 1'b0;
      for (c = 0; c < 60 && !fin; c++) begin
         @(negedge clk);
         if (w_valid && w_ready) begin
            checks++;
            if ({w_data, w_last, w_strb} !== {32'h100 + 32'(n), n == 15, 4'hF}) begin
               errors++;
               $display("FAIL dirty_beat%0d got data=%h last=%b strb=%h want data=%h last=%b strb=f",
                        n, w_data, w_last, w_strb, 32'h100 + 32'(n), n == 15);
            end
            fin = w_last;
            n++;
         end
      end
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL dirty_beat_count got %0d want 16", n);
      end
      c = 0;
      while (!b_ready && c < 10) begin @(negedge clk); c++; end
      checks++;
      if ({b_ready, lookup_hit, dut.count} !== {1'b1, 1'b1, 3'd1}) begin
         errors++;
         $display("FAIL dirty_b_wait got bready=%b hit=%b count=%0d want 1 1 1",
                  b_ready, lookup_hit, dut.count);
      end
      repeat (3) @(posedge clk);
      #1 b_valid = 1'b1;
      @(posedge clk); #1 b_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({b_ready, lookup_hit, dut.count} !== 5'b0) begin
         errors++;
         $display("FAIL dirty_freed got bready=%b hit=%b count=%0d want 0 0 0",
                  b_ready, lookup_hit, dut.count);
      end
   endtask

   task automatic test_fill();
      int c, k;
      logic early, acc;
      logic [31:0] exp_addr [4];
      do_reset();
      aw_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         enq(32'h1000_0000 + 32'(i) * 32'h40, 1'b1, 2'(i), 32'h1000 * 32'(i));
         @(negedge clk);
         checks++;
         if ({wend, wend_miss_idx} !== {1'b1, 2'(i)}) begin
            errors++;
            $display("FAIL fill_wend%0d got wend=%b idx=%0d want 1 %0d", i, wend, wend_miss_idx, i);
         end
      end
      checks++;
      if ({enq_ready, dut.count} !== {1'b0, 3'd4}) begin
         errors++;
         $display("FAIL fill_full got ready=%b count=%0d want 0 4", enq_ready, dut.count);
      end
      enq_valid = 1'b1; enq_dirty = 1'b1; enq_addr = 32'h1000_0400; enq_miss_idx = 2'd1;
      enq_data = make_line(32'h5000);
      early = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (wend) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL fill_blocked_wend got 1 want 0");
      end
      aw_ready = 1'b1;
      acc = 1'b0;
      for (c = 0; c < 100 && !acc; c++) begin
         @(negedge clk);
         if (wend) early = 1'b1;
         acc = enq_ready;
         b_valid = b_ready;
         @(posedge clk); #1 b_valid = 1'b0;
      end
      enq_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({acc, early, wend, wend_miss_idx} !== {1'b1, 1'b0, 1'b1, 2'd1}) begin
         errors++;
         $display("FAIL fill_fifth got acc=%b early=%b wend=%b idx=%0d want 1 0 1 1",
                  acc, early, wend, wend_miss_idx);
      end
      exp_addr = '{32'h1000_0040, 32'h1000_0080, 32'h1000_00C0, 32'h1000_0400};
      k = 0;
      for (c = 0; c < 400 && k < 4; c++) begin
         if (aw_valid && aw_ready) begin
            checks++;
            if (aw_addr !== exp_addr[k]) begin
               errors++;
               $display("FAIL fill_drain_addr%0d got %h want %h", k, aw_addr, exp_addr[k]);
            end
            k++;
         end
         b_valid = b_ready;
         @(posedge clk); #1 b_valid = 1'b0;
         @(negedge clk);
      end
      for (c = 0; c < 60 && dut.count != 0; c++) begin
         b_valid = b_ready;
         @(posedge clk); #1 b_valid = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (k != 4 || dut.count !== 3'd0) begin
         errors++;
         $display("FAIL fill_drained got bursts=%0d count=%0d want 4 0", k, dut.count);
      end
   endtask

   task automatic test_lookup();
      int c;
      logic fin;
      do_reset();
      aw_ready = 1'b0;
      lookup_addr = 32'h2000_0000;
      enq_valid = 1'b1; enq_dirty = 1'b1; enq_addr = 32'h2000_0000; enq_miss_idx = 2'd0;
      enq_data = make_line(32'h200);
      @(negedge clk);
      checks++;
      if (lookup_hit !== 1'b0) begin
         errors++;
         $display("FAIL lookup_enq_cycle got %b want 0", lookup_hit);
      end
      @(posedge clk); #1 enq_valid = 1'b0;
      lookup_addr = 32'h2000_003C; #1;
      checks++;
      if (lookup_hit !== 1'b1) begin
         errors++;
         $display("FAIL lookup_same_block got %b want 1", lookup_hit);
      end
      lookup_addr = 32'h2000_0040; #1;
      checks++;
      if (lookup_hit !== 1'b0) begin
         errors++;
         $display("FAIL lookup_next_block got %b want 0", lookup_hit);
      end
      lookup_addr = 32'h2000_003C;
      aw_ready = 1'b1;
      fin = 1'b0;
      for (c = 0; c < 100 && !fin; c++) begin
         @(negedge clk);
         if (b_ready) begin
            b_valid = 1'b1; #1;
            checks++;
            if (lookup_hit !== 1'b1) begin
               errors++;
               $display("FAIL lookup_dequeue_cycle got %b want 1", lookup_hit);
            end
            fin = 1'b1;
         end
         @(posedge clk); #1 b_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({fin, lookup_hit} !== 2'b10) begin
         errors++;
         $display("FAIL lookup_after_b got done=%b hit=%b want 1 0", fin, lookup_hit);
      end
   endtask

   task automatic test_backpressure();
      int c, n;
      logic fin, stall;
      logic [32:0] prev;
      do_reset();
      enq(32'h4000_0080, 1'b1, 2'd0, 32'hA00);
      c = 0;
      @(negedge clk);
      while (!aw_valid && c < 10) begin @(negedge clk); c++; end
      checks++;
      if ({aw_valid, aw_addr} !== {1'b1, 32'h4000_0080}) begin
         errors++;
         $display("FAIL bp_aw got v=%b addr=%h want 1 40000080", aw_valid, aw_addr);
      end
      w_ready = 1'b0;
      n = 0; fin = 1'b0; stall = 1'b0; prev = '0;
      for (c = 0; c < 80 && !fin; c++) begin
         @(posedge clk); #1 w_ready = ~w_ready;
         @(negedge clk);
         if (stall) begin
            checks++;
            if ({w_data, w_last} !== prev) begin
               errors++;
               $display("FAIL bp_stable got %h want %h", {w_data, w_last}, prev);
            end
         end
         if (w_valid && w_ready) begin
            checks++;
            if ({w_data, w_last} !== {32'hA00 + 32'(n), n == 15}) begin
               errors++;
               $display("FAIL bp_beat%0d got data=%h last=%b want %h %b",
                        n, w_data, w_last, 32'hA00 + 32'(n), n == 15);
            end
            fin = w_last;
            n++;
         end
         stall = w_valid && !w_ready;
         prev = {w_data, w_last};
      end
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL bp_beat_count got %0d want 16", n);
      end
      w_ready = 1'b1;
      c = 0;
      while (!b_ready && c < 10) begin @(negedge clk); c++; end
      b_valid = 1'b1;
      @(posedge clk); #1 b_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (dut.count !== 3'd0) begin
         errors++;
         $display("FAIL bp_freed got count=%0d want 0", dut.count);
      end
   endtask

   task automatic test_error_reset();
      int c, n, seen;
      logic hit7;
      do_reset();
      lookup_addr = 32'h6000_0040;
      enq(32'h6000_0000, 1'b1, 2'd0, 32'h600);
      c = 0;
      @(negedge clk);
      while (!b_ready && c < 40) begin @(negedge clk); c++; end
      b_resp = 2'b10; b_valid = 1'b1;
      @(posedge clk); #1 b_valid = 1'b0; b_resp = 2'b00;
      @(negedge clk);
      checks++;
      if (wb_error !== 1'b1) begin
         errors++;
         $display("FAIL err_set got %b want 1", wb_error);
      end
      enq(32'h6000_0040, 1'b1, 2'd1, 32'h700);
      @(negedge clk);
      checks++;
      if ({wb_error, wend} !== 2'b11) begin
         errors++;
         $display("FAIL err_sticky got err=%b wend=%b want 1 1", wb_error, wend);
      end
      n = 0; hit7 = 1'b0;
      for (c = 0; c < 60 && !hit7; c++) begin
         @(negedge clk);
         if (w_valid && w_ready) begin
            if (n == 7) hit7 = 1'b1;
            else n++;
         end
      end
      checks++;
      if ({hit7, w_data} !== {1'b1, 32'h707}) begin
         errors++;
         $display("FAIL err_beat7 got reached=%b data=%h want 1 00000707", hit7, w_data);
      end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({aw_valid, w_valid, b_ready, lookup_hit, wb_error, dut.count} !== 8'b0) begin
         errors++;
         $display("FAIL err_midburst_reset got aw=%b w=%b b=%b hit=%b err=%b count=%0d want all 0",
                  aw_valid, w_valid, b_ready, lookup_hit, wb_error, dut.count);
      end
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (aw_valid || w_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL err_dropped got bus_cycles=%0d want 0", seen);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_clean_enqueue();
      test_dirty_burst();
      test_fill();
      test_lookup();
      test_backpressure();
      test_error_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
